// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one shift-add multiplier among NREQ requesters.
// The granted requester's operands are captured once; the product is returned with a one-cycle done pulse.
module mult_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int CW    = 3
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   mplier,
    input  logic [NREQ*WIDTH-1:0]   mcand,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [NREQ-1:0]         done,
    output logic [2*WIDTH-1:0]      product
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TEST  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [IW-1:0]        last_gnt_q, last_gnt_d;
    logic                 c_q, c_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 hi_found, lo_found;
    logic [IW-1:0]        hi_idx, lo_idx, win_idx;
    logic [WIDTH-1:0]     sel_mplier, sel_mcand;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IW'(NREQ - 1);
            c_q        <= 1'b0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            count_q    <= '0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            c_q        <= c_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            count_q    <= count_d;
            product_q  <= product_d;
        end
    end

    // Winner: lowest requester above last_gnt if any, otherwise lowest overall (wrap).
    always_comb begin
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        sel_mplier = '0;
        sel_mcand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (IW'(i) > last_gnt_q) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_idx) begin
                sel_mplier = mplier[i*WIDTH +: WIDTH];
                sel_mcand  = mcand[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        c_d        = c_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        count_d    = count_q;
        product_d  = product_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    last_gnt_d = win_idx;
                    m_d        = sel_mcand;
                    q_d        = sel_mplier;
                    c_d        = 1'b0;
                    a_d        = '0;
                    count_d    = '0;
                    state_d    = S_TEST;
                end
            end
            S_TEST: begin
                state_d = q_q[0] ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
                count_d         = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    // Capture the post-shift {A,Q}; the carry has already shifted into A.
                    product_d = {c_q, a_q, q_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end else begin
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE) ? gnt_q : '0;
    assign product = product_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: products, latencies, round-robin order,
// async reset mid-operation and operand capture at the grant edge.
module tb_mult_share_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int CW    = 3;

    logic                  Clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mplier;
    logic [NREQ*WIDTH-1:0] mcand;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic [2*WIDTH-1:0]    product;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CW(CW)) dut (
        .Clk     (Clk),
        .reset   (reset),
        .req     (req),
        .mplier  (mplier),
        .mcand   (mcand),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
    endtask

    // Waits (at negedges) for a grant; returns the cycle of the grant edge.
    task automatic wait_gnt(output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 100) begin
            @(negedge Clk);
            if (gnt != '0) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) check_val("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 100) begin
            @(negedge Clk);
            if (done != '0) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    // One isolated operation for requester idx; optionally scrambles operands after the grant.
    task automatic run_op(input int idx, input logic [WIDTH-1:0] mp, input logic [WIDTH-1:0] mc,
                          input logic [2*WIDTH-1:0] exp_p, input int exp_lat, input bit mutate);
        int g_at, d_at, pulses;
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << idx;
        mplier[idx*WIDTH +: WIDTH] = mp;
        mcand[idx*WIDTH +: WIDTH]  = mc;
        req = oh;
        wait_gnt(g_at);
        check_val("op_gnt", 32'(gnt), 32'(oh));
        check_val("op_busy", 32'(busy), 32'd1);
        req = '0;
        if (mutate) begin
            mplier[idx*WIDTH +: WIDTH] = ~mp;
            mcand[idx*WIDTH +: WIDTH]  = ~mc;
        end
        wait_done(d_at);
        check_val("op_latency", 32'(d_at - g_at), 32'(exp_lat));
        check_val("op_product", 32'(product), 32'(exp_p));
        check_val("op_done", 32'(done), 32'(oh));
        pulses = 1;
        @(negedge Clk);
        check_val("op_done_clear", 32'(done), 32'd0);
        check_val("op_gnt_clear", 32'(gnt), 32'd0);
        check_val("op_busy_clear", 32'(busy), 32'd0);
        if (mutate) begin
            for (int k = 0; k < 12; k++) begin
                @(negedge Clk);
                if (done != '0) pulses++;
            end
            check_val("mut_pulses", 32'(pulses), 32'd1);
            check_val("mut_product_held", 32'(product), 32'(exp_p));
        end
    endtask

    initial begin
        int g_at, d_at, prev_d;
        logic [NREQ-1:0] exp_g;
        reset  = 1'b1;
        req    = '0;
        mplier = '0;
        mcand  = '0;
        @(negedge Clk);
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_product", 32'(product), 32'd0);
        @(negedge Clk);
        reset = 1'b0;

        // 11 * 5 = 55, popcount 3 -> latency 11
        run_op(0, 4'b1011, 4'b0101, 8'h37, 11, 1'b0);

        // Round-robin with all requesters pending: 3 * 1, popcount 2 -> latency 10
        do_reset();
        mplier = {NREQ{4'b0011}};
        mcand  = {NREQ{4'b0001}};
        req    = '1;
        prev_d = -1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g_at);
            exp_g = NREQ'(1) << (k % NREQ);
            check_val("rr_gnt", 32'(gnt), 32'(exp_g));
            if (prev_d >= 0) check_val("rr_gap", 32'(g_at - prev_d), 32'd2);
            if (k == 4) req = '0;
            wait_done(d_at);
            check_val("rr_latency", 32'(d_at - g_at), 32'd10);
            check_val("rr_product", 32'(product), 32'h03);
            check_val("rr_done", 32'(done), 32'(exp_g));
            prev_d = d_at;
            @(negedge Clk);
            check_val("rr_no_overlap", 32'(gnt), 32'd0);
        end

        // Carry path and sparse multiplier
        mplier = '0;
        mcand  = '0;
        run_op(3, 4'b1111, 4'b1111, 8'hE1, 12, 1'b0);
        run_op(3, 4'b1001, 4'b1111, 8'h87, 10, 1'b0);

        // Zero operands
        run_op(1, 4'b0000, 4'b1111, 8'h00, 8, 1'b0);
        run_op(2, 4'b0001, 4'b0000, 8'h00, 9, 1'b0);

        // Leave a nonzero product, then reset during ADD of a req2 operation
        run_op(2, 4'b0011, 4'b0101, 8'h0F, 10, 1'b0);
        mplier[2*WIDTH +: WIDTH] = 4'b0001;
        mcand[2*WIDTH +: WIDTH]  = 4'b0011;
        req = 4'b0100;
        wait_gnt(g_at);
        check_val("pre_rst_gnt", 32'(gnt), 32'b0100);
        @(negedge Clk);
        #2 reset = 1'b1;
        #1;
        check_val("arst_gnt", 32'(gnt), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_product", 32'(product), 32'd0);
        @(negedge Clk);
        mplier[0 +: WIDTH]       = 4'b0010;
        mcand[0 +: WIDTH]        = 4'b0011;
        mplier[2*WIDTH +: WIDTH] = 4'b0001;
        mcand[2*WIDTH +: WIDTH]  = 4'b0111;
        req   = 4'b0101;
        reset = 1'b0;
        wait_gnt(g_at);
        check_val("post_rst_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0100;
        wait_done(d_at);
        check_val("post_rst_lat0", 32'(d_at - g_at), 32'd9);
        check_val("post_rst_prod0", 32'(product), 32'h06);
        wait_gnt(g_at);
        check_val("post_rst_gnt2", 32'(gnt), 32'b0100);
        req = '0;
        wait_done(d_at);
        check_val("post_rst_lat2", 32'(d_at - g_at), 32'd9);
        check_val("post_rst_prod2", 32'(product), 32'h07);
        @(negedge Clk);

        // Operands and req change after the grant: 13 * 6 = 78
        run_op(1, 4'b1101, 4'b0110, 8'h4E, 11, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
